cs_seq_ctrl: RTL and testbench

- Sequencer for the CS 9-tap window filter datapath (X 8-bit in, Y 10-bit out).
- On a start command it:
  - resets the CS core;
  - streams n_samp samples from an input sample RAM into X, one per cycle;
  - skips the 8-sample window warm-up;
  - writes each valid Y into a result RAM, then pulses done.
- Sits between the sample/result memories and the CS instance in the filter subsystem.

---
 rtl/cs_pkg.sv | 16 +
 rtl/cs_seq_pipe.sv | 48 ++++
 rtl/cs_seq_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_cs_seq_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/cs_pkg.sv
// Shared types and constants for the CS filter sequencer.
package cs_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        STREAM,
        DONE,
        ABORT
    } state_e;

    localparam int WIN = 9;
    localparam int X_W = 8;
    localparam int Y_W = 10;

endpackage

// File: rtl/cs_seq_pipe.sv
// Valid/index shift register that follows each sample read through the
// RAM, X register and CS latency so the result write knows its index.
module cs_seq_pipe #(
    parameter int DEPTH = 4,
    parameter int IW    = 15
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          in_vld,
    input  logic [IW-1:0] in_idx,
    output logic          x_vld,
    output logic          wr_vld,
    output logic [IW-1:0] wr_idx
);

    logic [DEPTH-1:1]         vld_d, vld_q;
    logic [DEPTH-1:1][IW-1:0] idx_d, idx_q;

    always_comb begin
        vld_d    = vld_q;
        idx_d    = idx_q;
        vld_d[1] = in_vld;
        idx_d[1] = in_idx;
        for (int k = 2; k < DEPTH; k++) begin
            vld_d[k] = vld_q[k-1];
            idx_d[k] = idx_q[k-1];
        end
        if (flush) vld_d = '0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            vld_q <= '0;
            idx_q <= '0;
        end else begin
            vld_q <= vld_d;
            idx_q <= idx_d;
        end
    end

    // Stage 1 is the cycle in_rdata is on the bus; the last stage is the
    // cycle Y is valid, which the top registers into the write.
    assign x_vld  = vld_q[1];
    assign wr_vld = vld_q[DEPTH-1];
    assign wr_idx = idx_q[DEPTH-1];

endmodule

// File: rtl/cs_seq_ctrl.sv
// Sequencer: resets the CS core, streams samples from RAM into X and
// writes each valid Y to the result RAM, then pulses done.
module cs_seq_ctrl #(
    parameter int AW      = 14,
    parameter int WIN     = cs_pkg::WIN,
    parameter int CS_LAT  = 1,
    parameter int RST_CYC = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [AW:0]          n_samp,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic                 in_re,
    output logic [AW-1:0]        in_addr,
    input  logic [cs_pkg::X_W-1:0] in_rdata,
    output logic                 cs_reset,
    output logic [cs_pkg::X_W-1:0] cs_x,
    input  logic [cs_pkg::Y_W-1:0] cs_y,
    output logic                 out_we,
    output logic [AW-1:0]        out_addr,
    output logic [cs_pkg::Y_W-1:0] out_wdata
);
    import cs_pkg::*;

    localparam int IW    = AW + 1;
    localparam int DEPTH = 3 + CS_LAT;
    localparam int CW    = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
    localparam logic [IW-1:0] N_MIN = IW'(WIN);
    localparam logic [IW-1:0] N_MAX = {1'b1, {AW{1'b0}}};
    localparam logic [IW-1:0] WOFF  = IW'(WIN - 1);

    state_e         state_q, state_d;
    logic [IW-1:0]  n_q, n_d;
    logic [IW-1:0]  rd_idx_q, rd_idx_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic           in_re_q, in_re_d, cs_reset_q, cs_reset_d;
    logic           out_we_q, out_we_d, wr_last_q, wr_last_d;
    logic [AW-1:0]  out_addr_q, out_addr_d;
    logic [X_W-1:0] cs_x_q, cs_x_d;
    logic [Y_W-1:0] out_wdata_q, out_wdata_d;

    logic           pipe_flush, x_vld, wr_vld;
    logic [IW-1:0]  wr_idx;

    assign pipe_flush = abort && (state_q != IDLE);

    cs_seq_pipe #(
        .DEPTH (DEPTH),
        .IW    (IW)
    ) u_pipe (
        .clk    (clk),
        .reset  (reset),
        .flush  (pipe_flush),
        .in_vld (in_re_q),
        .in_idx (rd_idx_q),
        .x_vld  (x_vld),
        .wr_vld (wr_vld),
        .wr_idx (wr_idx)
    );

    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        rd_idx_d    = rd_idx_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        in_re_d     = 1'b0;
        cs_reset_d  = cs_reset_q;
        cs_x_d      = cs_x_q;
        out_we_d    = 1'b0;
        out_addr_d  = out_addr_q;
        out_wdata_d = out_wdata_q;
        wr_last_d   = wr_last_q;

        if (x_vld) cs_x_d = in_rdata;
        // Entries before WIN-1 are window warm-up and produce no write.
        if (wr_vld && wr_idx >= WOFF) begin
            out_we_d    = 1'b1;
            out_addr_d  = AW'(wr_idx - WOFF);
            out_wdata_d = cs_y;
            wr_last_d   = (wr_idx == n_q - 1'b1);
        end

        case (state_q)
            IDLE: begin
                cs_reset_d = 1'b0;
                busy_d     = 1'b0;
                if (start && !abort) begin
                    if (n_samp >= N_MIN && n_samp <= N_MAX) begin
                        n_d        = n_samp;
                        busy_d     = 1'b1;
                        cs_reset_d = 1'b1;
                        cs_x_d     = '0;
                        cnt_d      = '0;
                        state_d    = CLR;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            CLR: begin
                cs_x_d = '0;
                if (cnt_q == CW'(RST_CYC - 1)) begin
                    cs_reset_d = 1'b0;
                    in_re_d    = 1'b1;
                    rd_idx_d   = '0;
                    state_d    = STREAM;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STREAM: begin
                if (in_re_q) begin
                    rd_idx_d = rd_idx_q + 1'b1;
                    in_re_d  = (rd_idx_q + 1'b1) < n_q;
                end
                if (out_we_q && wr_last_q) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            ABORT: begin
                if (cnt_q == CW'(RST_CYC - 1)) begin
                    cs_reset_d = 1'b0;
                    state_d    = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (pipe_flush) begin
            in_re_d    = 1'b0;
            out_we_d   = 1'b0;
            busy_d     = 1'b0;
            done_d     = 1'b0;
            cs_reset_d = 1'b1;
            cnt_d      = '0;
            state_d    = ABORT;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            n_q         <= '0;
            rd_idx_q    <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            in_re_q     <= 1'b0;
            cs_reset_q  <= 1'b1;
            out_we_q    <= 1'b0;
            wr_last_q   <= 1'b0;
            out_addr_q  <= '0;
            cs_x_q      <= '0;
            out_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            rd_idx_q    <= rd_idx_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            in_re_q     <= in_re_d;
            cs_reset_q  <= cs_reset_d;
            out_we_q    <= out_we_d;
            wr_last_q   <= wr_last_d;
            out_addr_q  <= out_addr_d;
            cs_x_q      <= cs_x_d;
            out_wdata_q <= out_wdata_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign in_re     = in_re_q;
    assign in_addr   = rd_idx_q[AW-1:0];
    assign cs_reset  = cs_reset_q;
    assign cs_x      = cs_x_q;
    assign out_we    = out_we_q;
    assign out_addr  = out_addr_q;
    assign out_wdata = out_wdata_q;

endmodule

// File: tb/tb_cs_seq_ctrl.sv
// Bench for cs_seq_ctrl: sample RAM, behavioural 9-tap CS core and a
// result scoreboard computed from window sums of the sample RAM.
module tb_cs_seq_ctrl;

    localparam int AW      = 14;
    localparam int WIN     = 9;
    localparam int CS_LAT  = 1;
    localparam int RST_CYC = 2;
    localparam int FIRST_WR = RST_CYC + WIN + 3 + CS_LAT;

    logic          clk = 1'b0;
    logic          reset, start, abort;
    logic [AW:0]   n_samp;
    logic          busy, done, err, in_re, cs_reset, out_we;
    logic [AW-1:0] in_addr, out_addr;
    logic [7:0]    in_rdata, cs_x;
    logic [9:0]    cs_y, out_wdata;

    logic [7:0]    smem [0:(1<<AW)-1];
    logic [7:0]    cs_win [0:WIN-2];

    int n_chk = 0, n_fail = 0;
    int cyc, wr_cnt, rd_cnt, first_wr, last_wr, last_addr, done_cnt, done_cyc;
    int gap_err, addr_err, data_err, busy_err, rdaddr_err;

    always #5 clk = ~clk;

    cs_seq_ctrl #(.AW(AW), .WIN(WIN), .CS_LAT(CS_LAT), .RST_CYC(RST_CYC)) dut (
        .clk(clk), .reset(reset), .start(start), .n_samp(n_samp), .abort(abort),
        .busy(busy), .done(done), .err(err), .in_re(in_re), .in_addr(in_addr),
        .in_rdata(in_rdata), .cs_reset(cs_reset), .cs_x(cs_x), .cs_y(cs_y),
        .out_we(out_we), .out_addr(out_addr), .out_wdata(out_wdata)
    );

    always @(posedge clk) if (in_re) in_rdata <= smem[in_addr];

    // CS core model: Y is the 10-bit wrapped sum of the last 9 captured X.
    always @(posedge clk) begin
        if (cs_reset) begin
            for (int k = 0; k < WIN-1; k++) cs_win[k] <= '0;
            cs_y <= '0;
        end else begin
            logic [9:0] s;
            s = 10'(cs_x);
            for (int k = 0; k < WIN-1; k++) s = s + 10'(cs_win[k]);
            cs_win[0] <= cs_x;
            for (int k = 1; k < WIN-1; k++) cs_win[k] <= cs_win[k-1];
            cs_y <= s;
        end
    end

    function automatic logic [9:0] exp_y(input int k);
        logic [9:0] s = '0;
        for (int j = 0; j < WIN; j++) s = s + 10'(smem[k+j]);
        return s;
    endfunction

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_chk++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_rst(input string pfx);
        chk({pfx, "_cs_reset"}, cs_reset, 1);
        chk({pfx, "_busy"}, busy, 0);
        chk({pfx, "_done"}, done, 0);
        chk({pfx, "_err"}, err, 0);
        chk({pfx, "_in_re"}, in_re, 0);
        chk({pfx, "_out_we"}, out_we, 0);
        chk({pfx, "_in_addr"}, in_addr, 0);
        chk({pfx, "_out_addr"}, out_addr, 0);
        chk({pfx, "_cs_x"}, cs_x, 0);
        chk({pfx, "_out_wdata"}, out_wdata, 0);
    endtask

    task automatic clr_stats();
        wr_cnt = 0; rd_cnt = 0; first_wr = -1; last_wr = -1; last_addr = -1;
        done_cnt = 0; done_cyc = -1; gap_err = 0; addr_err = 0; data_err = 0;
        busy_err = 0; rdaddr_err = 0;
    endtask

    task automatic observe();
        if (in_re) begin
            if (int'(in_addr) != rd_cnt % (1 << AW)) rdaddr_err++;
            rd_cnt++;
        end
        if (out_we) begin
            if (first_wr < 0) first_wr = cyc;
            else if (cyc != last_wr + 1) gap_err++;
            if (int'(out_addr) != wr_cnt) addr_err++;
            if (out_wdata != exp_y(wr_cnt)) data_err++;
            wr_cnt++; last_wr = cyc; last_addr = int'(out_addr);
        end
        if (done) begin done_cnt++; done_cyc = cyc; end
        if (done_cnt == 0 && !busy) busy_err++;
        if (done && busy) busy_err++;
    endtask

    task automatic run_full(input int n, input bit busy_starts);
        clr_stats();
        start = 1'b1; n_samp = (AW+1)'(n);
        @(negedge clk);
        start = 1'b0; cyc = 1;
        while (cyc < n + 100) begin
            observe();
            if (done_cnt != 0) break;
            start = busy_starts && busy && ($urandom_range(0, 7) == 0);
            n_samp = (AW+1)'($urandom_range(0, 20000));
            @(negedge clk); cyc++;
        end
        start = 1'b0;
        repeat (4) begin @(negedge clk); cyc++; observe(); end
        chk("wr_cnt", wr_cnt, n - WIN + 1);
        chk("rd_cnt", rd_cnt, n);
        chk("first_wr_lat", first_wr, FIRST_WR);
        chk("last_addr", last_addr, n - WIN);
        chk("done_cnt", done_cnt, 1);
        chk("done_after_last_wr", done_cyc - last_wr, 1);
        chk("wr_gap_err", gap_err, 0);
        chk("wr_addr_err", addr_err, 0);
        chk("wr_data_err", data_err, 0);
        chk("busy_err", busy_err, 0);
        chk("rd_addr_err", rdaddr_err, 0);
    endtask

    task automatic reject(input int n);
        int bad = 0;
        start = 1'b1; n_samp = (AW+1)'(n);
        @(negedge clk);
        start = 1'b0;
        chk("rej_err_pulse", err, 1);
        chk("rej_busy", busy, 0);
        @(negedge clk);
        chk("rej_err_one_cycle", err, 0);
        repeat (5) begin
            if (busy || in_re || cs_reset) bad++;
            @(negedge clk);
        end
        chk("rej_idle_quiet", bad, 0);
    endtask

    initial begin
        int bad;
        reset = 1'b0; start = 1'b0; abort = 1'b0; n_samp = '0;
        for (int i = 0; i < (1 << AW); i++) smem[i] = 8'($urandom);
        repeat (3) @(negedge clk);
        check_rst("init");
        reset = 1'b1;
        @(negedge clk);
        chk("idle_cs_reset", cs_reset, 0);

        for (int i = 0; i < 20; i++) smem[i] = 8'(8'h10 + i);
        run_full(20, 1'b0);
        run_full(9, 1'b0);

        reject(8);
        reject(0);
        reject((1 << AW) + 1);

        // abort and start together in IDLE: start is dropped
        start = 1'b1; abort = 1'b1; n_samp = 20;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("abst_busy", busy, 0);
        chk("abst_err", err, 0);
        @(negedge clk);
        chk("abst_in_re", in_re, 0);

        // abort during the 5th write of a long run
        clr_stats();
        start = 1'b1; n_samp = 100;
        @(negedge clk);
        start = 1'b0; cyc = 1;
        for (int t = 0; t < 200; t++) begin
            observe();
            if (wr_cnt == 5) break;
            @(negedge clk); cyc++;
        end
        chk("abort_reached_wr5", wr_cnt, 5);
        chk("abort_pre_data_err", data_err, 0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_out_we", out_we, 0);
        chk("abort_in_re", in_re, 0);
        chk("abort_busy", busy, 0);
        chk("abort_cs_reset1", cs_reset, 1);
        @(negedge clk);
        chk("abort_cs_reset2", cs_reset, 1);
        @(negedge clk);
        chk("abort_cs_reset_end", cs_reset, 0);
        bad = 0;
        repeat (20) begin
            if (done || out_we || in_re || busy) bad++;
            @(negedge clk);
        end
        chk("abort_quiet", bad, 0);
        run_full(12, 1'b0);

        // reset pulled low for one cycle mid-stream
        start = 1'b1; n_samp = 50;
        @(negedge clk);
        start = 1'b0;
        repeat (24) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_rst("midrst");
        reset = 1'b1;
        bad = 0;
        repeat (30) begin
            @(negedge clk);
            if (out_we || in_re || busy || done) bad++;
        end
        chk("midrst_quiet", bad, 0);
        run_full($urandom_range(WIN, 40), 1'b0);

        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 80; i++) smem[i] = 8'($urandom);
            run_full($urandom_range(WIN, 70), 1'b1);
        end

        run_full(1 << AW, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
        $finish;
    end

endmodule
